fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that lets NREQ producers share the single write port of the 16-deep, 8-bit synchronous FIFO. It sits between the producers and the FIFO's wr_en/din/full pins. It grants one requester at a time for a bounded burst and stalls on FIFO full without losing or duplicating data. It also keeps a free-running count of words written for debug and bench checking.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width, matches FIFO din
- BURST, 4, max words per grant (1..15)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*DW  requester i data in bits [i*DW +: DW]
- req_ready  out  NREQ  combinational; word on requester i accepted this cycle when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  combinational write strobe to FIFO
- fifo_din  out  DW  combinational mux of granted requester data
- grant_id  out  $clog2(NREQ)  currently/last granted requester
- busy  out  1  high while in GRANT
- words_written  out  16  count of FIFO writes, wraps at 65535->0

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any req_valid, select the first valid requester searching from (last_grant+1) mod NREQ upward, wrapping. Load grant_id, clear beat counter, go to GRANT. No transfer occurs in IDLE.
- GRANT: transfer = req_valid[grant_id] & ~fifo_full. On transfer, beat counter +1 and words_written +1.
- GRANT exit to IDLE, same edge, when either:
  - a transfer completes beat BURST, or
  - req_valid[grant_id] is 0.
- fifo_full in GRANT: no transfer, beat counter holds, grant held. Stall is unbounded.
- Requesters never granted see req_ready=0. A requester may drop valid at any time; it is never forced to hold.
- Fairness: after a grant ends, the same requester is searched last in the next IDLE.
- Beat counter width is $clog2(BURST+1). Only one write can occur per cycle.

## Timing
- Reset values: state IDLE, grant_id 0, last_grant NREQ-1 (first search starts at requester 0), beat 0, words_written 0, busy 0. fifo_wr_en=0 and req_ready=0 follow combinationally.
- fifo_wr_en = busy & req_valid[grant_id] & ~fifo_full. It equals req_ready[grant_id], and all other req_ready bits are 0.
- fifo_din = req_data[grant_id] whenever busy, else 0.
- Latency: valid asserted in cycle t while idle -> busy at t+1 -> first write at t+1 if not full.
- Grant handover costs one IDLE bubble cycle.
- Throughput per grant: BURST words in BURST cycles plus one bubble.
- fifo_full is sampled in the same cycle as the write. The FIFO updates full at the write edge, so a write into the 16th slot makes full=1 before the next cycle's decision.
- Simultaneous valid drop and full: no transfer, GRANT exits to IDLE.
- Reset asserted mid-burst: outputs go to reset values immediately and asynchronously; any word in flight that cycle is not written.

## Test plan
- Single requester 0 sends 0x10..0x15 with BURST=4 -> writes 0x10..0x13, one IDLE cycle, then 0x14,0x15. words_written=6. FIFO reads back the same order.
- All 4 requesters hold valid continuously, each driving a distinct tag (0xA0 + i*0x10 + beat) -> grants in order 0,1,2,3,0. Each grant writes exactly 4 words. grant_id never repeats back-to-back while others are valid.
- Fill: requester 2 streams 20 words from an empty FIFO, no reads -> exactly 16 writes, then fifo_wr_en=0 and req_ready[2]=0 while full. After 3 FIFO reads, exactly 3 more writes. No value is dropped or duplicated.
- Requester 1 drops valid after 2 beats while requester 3 is valid -> GRANT exits, IDLE for one cycle, then grant_id=3.
- Assert reset low mid-burst (beat 2) -> busy, fifo_wr_en, req_ready and words_written go to 0 asynchronously. After release, arbitration restarts from requester 0.
- Drive 65537 writes while draining the FIFO -> words_written wraps to 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter giving NREQ producers bounded bursts (BURST words) on one FIFO write port.
// Latency: grant one cycle after valid, first write in that same granted cycle; one idle bubble per handover.
// Backpressure: fifo_full stalls the current grant in place with no data loss; producers may drop valid at any time.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int GW   = $clog2(NREQ),
    localparam int BW   = $clog2(BURST + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_din,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [15:0]          words_written
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_q;
    logic [GW-1:0]   sel;
    logic [BW-1:0]   beat_q;
    logic [15:0]     words_q;
    logic            any_vld;
    logic            cur_vld;
    logic            xfer;
    logic            last_beat;
    logic [DW-1:0]   data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DW +: DW];
    end

    assign any_vld       = |req_valid;
    assign busy          = (state_q == GRANT);
    assign cur_vld       = req_valid[grant_q];
    assign xfer          = busy & cur_vld & ~fifo_full;
    assign last_beat     = (beat_q == BW'(BURST - 1));
    assign fifo_wr_en    = xfer;
    assign fifo_din      = busy ? data_arr[grant_q] : '0;
    assign grant_id      = grant_q;
    assign words_written = words_q;

    // Scan downward so the lowest offset from last_q+1 wins: previous owner is considered last.
    always_comb begin
        int cand;
        sel  = last_q;
        cand = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_q) + k) % NREQ;
            if (req_valid[cand[GW-1:0]]) begin
                sel = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (any_vld) state_d = GRANT;
            GRANT: if (!cur_vld || (xfer && last_beat)) state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NREQ - 1);
            beat_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            if (!busy && any_vld) begin
                grant_q <= sel;
                last_q  <= sel;
                beat_q  <= '0;
            end
            if (xfer) begin
                beat_q  <= beat_q + 1'b1;
                words_q <= words_q + 1'b1;
            end
        end
    end

endmodule
